ex_mem_wb_pipe: RTL and testbench
=================================

Name: ex_mem_wb_pipe

Overview:
- Holds the EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core.
- Captures EX-stage results and control bits, presents them to data memory, then to writeback.
- Directly produces the EX_MEM_* and MEM_WB_* fields that the forwarding control unit consumes.
- Handles data-memory stall, branch flush, and bubble insertion.

Parameters:
- DATA_W, 32, datapath width (ALU result, store data, load data).
- REG_W, 5, register-number width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ex_valid  input  1  EX holds a real instruction.
- ex_regWrite  input  1  instruction writes the register file.
- ex_memRead  input  1  instruction is a load.
- ex_memWrite  input  1  instruction is a store.
- ex_rd  input  REG_W  R-type destination.
- ex_rt  input  REG_W  load destination.
- ex_alu_result  input  DATA_W  ALU output / memory address.
- ex_store_data  input  DATA_W  store operand (already forwarded).
- mem_stall  input  1  data memory not ready this cycle.
- flush  input  1  squash the instruction currently in EX.
- mem_read_data  input  DATA_W  data-memory read data for the EX/MEM instruction.
- ex_hold  output  1  upstream must hold EX/ID/IF; equals mem_stall (combinational).
- EX_MEM_valid, EX_MEM_regWrite, EX_MEM_memRead, EX_MEM_memWrite  output  1 each.
- EX_MEM_rd  output  REG_W.
- EX_MEM_alu_result, EX_MEM_store_data  output  DATA_W.
- MEM_WB_valid, MEM_WB_regWrite, MEM_WB_memToReg  output  1 each.
- MEM_WB_rd, MEM_WB_rt  output  REG_W.
- MEM_WB_alu_result, MEM_WB_read_data  output  DATA_W.

Behaviour:
- Reset: every output register is 0, and flush_pend is 0. Reset overrides stall and flush in the same cycle.
- Latency: one cycle per stage. An EX instruction appears on EX_MEM_* on the next edge and on MEM_WB_* one edge later, unless stalled.
- Destination encoding is fixed:
  - Loads: EX_MEM_rd <= ex_rt. At the MEM/WB transfer, MEM_WB_rt <= EX_MEM_rd and MEM_WB_rd <= 0.
  - Non-loads: MEM_WB_rd <= EX_MEM_rd and MEM_WB_rt <= 0.
  - Consequence: the forwarding unit's rd and rt comparisons can never both match the same instruction.
- Bubble: valid, regWrite, memRead, memWrite and memToReg are 0, and rd and rt are 0. Data fields hold their previous values and are don't-care.
- Qualification: ex_regWrite, ex_memRead and ex_memWrite are ANDed with ex_valid on capture.
- Normal cycle (mem_stall=0):
  - EX/MEM captures EX, or a bubble if (flush | flush_pend).
  - MEM/WB captures EX/MEM; MEM_WB_read_data <= mem_read_data and MEM_WB_memToReg <= EX_MEM_memRead.
  - flush_pend is cleared.
- Stall cycle (mem_stall=1):
  - EX/MEM holds its value.
  - MEM/WB captures a bubble, so the writeback of the stalled instruction is not duplicated.
  - If flush is asserted, flush_pend is set to 1. The EX instruction is still presented after the stall and must be squashed then.
- Flush + stall in the same cycle: the older MEM instruction is preserved, and the flush is deferred through flush_pend.
- Flush never affects EX/MEM contents already captured, nor MEM/WB.
- Stall is released after N cycles: exactly one MEM/WB transfer of the held instruction occurs on the first non-stall edge.
- reg 0: destinations of 0 pass through unchanged. Suppressing them is the forwarding unit's job.

Optional Feature:
- Macro: EX_MEM_WB_PERF_EN.
- When defined, three extra outputs are present:
  - perf_stall_cnt[31:0]: +1 per clk with mem_stall=1.
  - perf_bubble_cnt[31:0]: +1 per MEM/WB bubble capture.
  - perf_retire_cnt[31:0]: +1 per MEM/WB capture with valid=1.
- Counters clear on reset and wrap modulo 2^32.
- When undefined, the ports and logic are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_W and REG_W defaults.
  - Struct ex_mem_t (valid, regWrite, memRead, memWrite, rd, alu_result, store_data).
  - Struct mem_wb_t (valid, regWrite, memToReg, rd, rt, alu_result, read_data).
  - Constants BUBBLE_EX_MEM and BUBBLE_MEM_WB.
- One natural sub-module: pipe_stage_reg.
  - Generic hold/load/bubble register with inputs load, hold, bubble, d, bubble_val.
  - Instantiated twice.

Test Plan:
- Reset, then 3 back-to-back R-types (rd=3,4,5, regWrite=1): EX_MEM_rd shows 3,4,5 on consecutive cycles; MEM_WB_rd shows 3,4,5 one cycle later, with MEM_WB_rt=0 each time.
- Load with ex_rt=7, ex_rd=9: EX_MEM_rd=7, EX_MEM_memRead=1; next cycle MEM_WB_rt=7, MEM_WB_rd=0, MEM_WB_memToReg=1, and MEM_WB_read_data equals mem_read_data (0xDEADBEEF).
- mem_stall high for 2 cycles with a store in EX/MEM: EX_MEM holds for 2 cycles; MEM_WB_valid=0 for 2 cycles; ex_hold=1; the store transfers once after release.
- flush=1 while mem_stall=1, then stall drops: EX/MEM receives a bubble (EX_MEM_valid=0, regWrite=0) on the release edge, and flush_pend returns to 0.
- reset asserted mid-stream with mem_stall=1 and flush=1: all outputs are 0 next edge, and flush_pend=0.
- EX_MEM_WB_PERF_EN defined, 10 cycles with 4 stall cycles and 1 flush: perf_stall_cnt=4, perf_bubble_cnt=4, perf_retire_cnt equals the retired valid count.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM and MEM/WB pipeline registers.
//   PIPE_DATA_W / PIPE_REG_W : default datapath and register-number widths.
//   ex_mem_t / mem_wb_t      : contents of each pipeline register.
//   BUBBLE_EX_MEM / _MEM_WB  : control-field values of an inserted bubble.
//   to_mem_wb()              : EX/MEM -> MEM/WB transfer with destination encoding.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_REG_W  = 5;

    typedef struct packed {
        logic                   valid;
        logic                   regWrite;
        logic                   memRead;
        logic                   memWrite;
        logic [PIPE_REG_W-1:0]  rd;
        logic [PIPE_DATA_W-1:0] alu_result;
        logic [PIPE_DATA_W-1:0] store_data;
    } ex_mem_t;

    typedef struct packed {
        logic                   valid;
        logic                   regWrite;
        logic                   memToReg;
        logic [PIPE_REG_W-1:0]  rd;
        logic [PIPE_REG_W-1:0]  rt;
        logic [PIPE_DATA_W-1:0] alu_result;
        logic [PIPE_DATA_W-1:0] read_data;
    } mem_wb_t;

    // Data fields of these constants are overwritten with the held values by the user.
    localparam ex_mem_t BUBBLE_EX_MEM = '0;
    localparam mem_wb_t BUBBLE_MEM_WB = '0;

    // Loads carry their destination in rt, everything else in rd, so the forwarding
    // unit can never match both comparisons against one instruction.
    function automatic mem_wb_t to_mem_wb(ex_mem_t em, logic [PIPE_DATA_W-1:0] rdata);
        mem_wb_t wb;
        wb.valid      = em.valid;
        wb.regWrite   = em.regWrite;
        wb.memToReg   = em.memRead;
        wb.rd         = em.memRead ? '0 : em.rd;
        wb.rt         = em.memRead ? em.rd : '0;
        wb.alu_result = em.alu_result;
        wb.read_data  = rdata;
        return wb;
    endfunction

endpackage

// File: rtl/ex_mem_wb_pipe_if.sv
// Bus between the EX stage / data memory / forwarding unit and ex_mem_wb_pipe.
//   master : upstream side (drives EX fields, mem_stall, flush, mem_read_data).
//   slave  : the pipeline registers (drive ex_hold, EX_MEM_*, MEM_WB_*).
// Optional macro EX_MEM_WB_PERF_EN adds perf_stall_cnt/perf_bubble_cnt/perf_retire_cnt.
interface ex_mem_wb_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
);
    logic              ex_valid;
    logic              ex_regWrite;
    logic              ex_memRead;
    logic              ex_memWrite;
    logic [REG_W-1:0]  ex_rd;
    logic [REG_W-1:0]  ex_rt;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_store_data;
    logic              mem_stall;
    logic              flush;
    logic [DATA_W-1:0] mem_read_data;

    logic              ex_hold;
    logic              EX_MEM_valid;
    logic              EX_MEM_regWrite;
    logic              EX_MEM_memRead;
    logic              EX_MEM_memWrite;
    logic [REG_W-1:0]  EX_MEM_rd;
    logic [DATA_W-1:0] EX_MEM_alu_result;
    logic [DATA_W-1:0] EX_MEM_store_data;
    logic              MEM_WB_valid;
    logic              MEM_WB_regWrite;
    logic              MEM_WB_memToReg;
    logic [REG_W-1:0]  MEM_WB_rd;
    logic [REG_W-1:0]  MEM_WB_rt;
    logic [DATA_W-1:0] MEM_WB_alu_result;
    logic [DATA_W-1:0] MEM_WB_read_data;
`ifdef EX_MEM_WB_PERF_EN
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_bubble_cnt;
    logic [31:0]       perf_retire_cnt;
`endif

    modport master (
        output ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_rd, ex_rt,
               ex_alu_result, ex_store_data, mem_stall, flush, mem_read_data,
        input  ex_hold, EX_MEM_valid, EX_MEM_regWrite, EX_MEM_memRead, EX_MEM_memWrite,
               EX_MEM_rd, EX_MEM_alu_result, EX_MEM_store_data, MEM_WB_valid,
               MEM_WB_regWrite, MEM_WB_memToReg, MEM_WB_rd, MEM_WB_rt,
               MEM_WB_alu_result, MEM_WB_read_data
`ifdef EX_MEM_WB_PERF_EN
        , input perf_stall_cnt, perf_bubble_cnt, perf_retire_cnt
`endif
    );

    modport slave (
        input  ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_rd, ex_rt,
               ex_alu_result, ex_store_data, mem_stall, flush, mem_read_data,
        output ex_hold, EX_MEM_valid, EX_MEM_regWrite, EX_MEM_memRead, EX_MEM_memWrite,
               EX_MEM_rd, EX_MEM_alu_result, EX_MEM_store_data, MEM_WB_valid,
               MEM_WB_regWrite, MEM_WB_memToReg, MEM_WB_rd, MEM_WB_rt,
               MEM_WB_alu_result, MEM_WB_read_data
`ifdef EX_MEM_WB_PERF_EN
        , output perf_stall_cnt, perf_bubble_cnt, perf_retire_cnt
`endif
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register.
//   clk, reset : rising-edge clock, synchronous active-high reset (clears to 0).
//   hold       : keep current contents (highest priority after reset).
//   bubble     : load bubble_val.
//   load       : load d.
//   q          : registered contents.
module pipe_stage_reg #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic hold,
    input  logic bubble,
    input  T     d,
    input  T     bubble_val,
    output T     q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (!hold) begin
            if (bubble) begin
                q <= bubble_val;
            end else if (load) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core.
//   clk, reset : rising-edge clock, synchronous active-high reset.
//   bus        : ex_mem_wb_pipe_if.slave; EX inputs, mem_stall, flush, mem_read_data in;
//                ex_hold, EX_MEM_* and MEM_WB_* (forwarding-unit fields) out.
// Optional macro EX_MEM_WB_PERF_EN adds stall/bubble/retire counters on the bus.
// DATA_W/REG_W must match the pipe_pkg widths used by the register structs.
module ex_mem_wb_pipe
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = pipe_pkg::PIPE_DATA_W,
    parameter int unsigned REG_W  = pipe_pkg::PIPE_REG_W
) (
    input logic             clk,
    input logic             reset,
    ex_mem_wb_pipe_if.slave bus
);

    ex_mem_t ex_mem_d, ex_mem_q, ex_mem_bubble;
    mem_wb_t mem_wb_d, mem_wb_q, mem_wb_bubble;
    logic    flush_pend_d, flush_pend_q;
    logic    squash_ex;

    // A flush seen during a stall targets the EX instruction that is still presented
    // after the stall, so it is remembered until the first non-stall edge.
    assign squash_ex = bus.flush | flush_pend_q;

    always_comb begin
        flush_pend_d = bus.mem_stall ? (flush_pend_q | bus.flush) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        ex_mem_d            = BUBBLE_EX_MEM;
        ex_mem_d.valid      = bus.ex_valid;
        ex_mem_d.regWrite   = bus.ex_regWrite & bus.ex_valid;
        ex_mem_d.memRead    = bus.ex_memRead & bus.ex_valid;
        ex_mem_d.memWrite   = bus.ex_memWrite & bus.ex_valid;
        if (bus.ex_valid) begin
            ex_mem_d.rd = bus.ex_memRead ? bus.ex_rt : bus.ex_rd;
        end
        ex_mem_d.alu_result = bus.ex_alu_result;
        ex_mem_d.store_data = bus.ex_store_data;

        ex_mem_bubble            = BUBBLE_EX_MEM;
        ex_mem_bubble.alu_result = ex_mem_q.alu_result;
        ex_mem_bubble.store_data = ex_mem_q.store_data;
    end

    always_comb begin
        mem_wb_d = to_mem_wb(ex_mem_q, bus.mem_read_data);

        mem_wb_bubble            = BUBBLE_MEM_WB;
        mem_wb_bubble.alu_result = mem_wb_q.alu_result;
        mem_wb_bubble.read_data  = mem_wb_q.read_data;
    end

    pipe_stage_reg #(
        .T (ex_mem_t)
    ) u_ex_mem (
        .clk        (clk),
        .reset      (reset),
        .load       (1'b1),
        .hold       (bus.mem_stall),
        .bubble     (squash_ex),
        .d          (ex_mem_d),
        .bubble_val (ex_mem_bubble),
        .q          (ex_mem_q)
    );

    // While MEM is stalled, WB gets bubbles so the held instruction retires only once.
    pipe_stage_reg #(
        .T (mem_wb_t)
    ) u_mem_wb (
        .clk        (clk),
        .reset      (reset),
        .load       (1'b1),
        .hold       (1'b0),
        .bubble     (bus.mem_stall),
        .d          (mem_wb_d),
        .bubble_val (mem_wb_bubble),
        .q          (mem_wb_q)
    );

    assign bus.ex_hold           = bus.mem_stall;
    assign bus.EX_MEM_valid      = ex_mem_q.valid;
    assign bus.EX_MEM_regWrite   = ex_mem_q.regWrite;
    assign bus.EX_MEM_memRead    = ex_mem_q.memRead;
    assign bus.EX_MEM_memWrite   = ex_mem_q.memWrite;
    assign bus.EX_MEM_rd         = ex_mem_q.rd;
    assign bus.EX_MEM_alu_result = ex_mem_q.alu_result;
    assign bus.EX_MEM_store_data = ex_mem_q.store_data;
    assign bus.MEM_WB_valid      = mem_wb_q.valid;
    assign bus.MEM_WB_regWrite   = mem_wb_q.regWrite;
    assign bus.MEM_WB_memToReg   = mem_wb_q.memToReg;
    assign bus.MEM_WB_rd         = mem_wb_q.rd;
    assign bus.MEM_WB_rt         = mem_wb_q.rt;
    assign bus.MEM_WB_alu_result = mem_wb_q.alu_result;
    assign bus.MEM_WB_read_data  = mem_wb_q.read_data;

`ifdef EX_MEM_WB_PERF_EN
    logic [31:0] perf_stall_q, perf_bubble_q, perf_retire_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
            perf_retire_q <= '0;
        end else if (bus.mem_stall) begin
            perf_stall_q  <= perf_stall_q + 32'd1;
            perf_bubble_q <= perf_bubble_q + 32'd1;
        end else if (ex_mem_q.valid) begin
            perf_retire_q <= perf_retire_q + 32'd1;
        end
    end

    assign bus.perf_stall_cnt  = perf_stall_q;
    assign bus.perf_bubble_cnt = perf_bubble_q;
    assign bus.perf_retire_cnt = perf_retire_q;
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
module tb_ex_mem_wb_pipe;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ex_mem_wb_pipe_if #(.DATA_W(32), .REG_W(5)) bus ();

    ex_mem_wb_pipe #(
        .DATA_W (32),
        .REG_W  (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction sitting in the MEM stage, as the model sees it.
    typedef struct {
        bit          valid;
        bit          rw;
        bit          mr;
        bit          mw;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] sd;
    } slot_t;

    // Expected writeback record.
    typedef struct {
        logic [4:0]  rd;
        logic [4:0]  rt;
        bit          rw;
        bit          m2r;
        logic [31:0] alu;
        logic [31:0] rdata;
    } wb_t;

    slot_t       mem_slot;
    bit          pend;
    bit          exp_wb_valid;
    bit          after_reset;
    bit          mon_en;
    wb_t         wb_q[$];
    int          n_vec;
    int          n_err;
    int unsigned m_stall, m_bub, m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Model advance for one clock edge, computed from the pipeline's rules.
    task automatic model_edge();
        wb_t w;
        if (reset) begin
            mem_slot     = '{default: '0};
            pend         = 1'b0;
            exp_wb_valid = 1'b0;
            after_reset  = 1'b1;
            m_stall = 0; m_bub = 0; m_ret = 0;
            wb_q.delete();
        end else begin
            after_reset = 1'b0;
            if (bus.mem_stall) begin
                m_stall++;
                m_bub++;
                exp_wb_valid = 1'b0;
                if (bus.flush) pend = 1'b1;
            end else begin
                exp_wb_valid = mem_slot.valid;
                if (mem_slot.valid) begin
                    m_ret++;
                    w.rd    = mem_slot.mr ? 5'd0 : mem_slot.dest;
                    w.rt    = mem_slot.mr ? mem_slot.dest : 5'd0;
                    w.rw    = mem_slot.rw;
                    w.m2r   = mem_slot.mr;
                    w.alu   = mem_slot.alu;
                    w.rdata = bus.mem_read_data;
                    wb_q.push_back(w);
                end
                if (bus.flush || pend || !bus.ex_valid) begin
                    mem_slot = '{default: '0};
                end else begin
                    mem_slot.valid = 1'b1;
                    mem_slot.rw    = bus.ex_regWrite;
                    mem_slot.mr    = bus.ex_memRead;
                    mem_slot.mw    = bus.ex_memWrite;
                    mem_slot.dest  = bus.ex_memRead ? bus.ex_rt : bus.ex_rd;
                    mem_slot.alu   = bus.ex_alu_result;
                    mem_slot.sd    = bus.ex_store_data;
                end
                pend = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, then let one edge happen.
    task automatic step(input bit v, input bit rw, input bit mr, input bit mw,
                        input logic [4:0] rd, input logic [4:0] rt,
                        input logic [31:0] alu, input logic [31:0] sd,
                        input bit stall, input bit fl, input bit rst,
                        input logic [31:0] rdata);
        bus.ex_valid      = v;
        bus.ex_regWrite   = rw;
        bus.ex_memRead    = mr;
        bus.ex_memWrite   = mw;
        bus.ex_rd         = rd;
        bus.ex_rt         = rt;
        bus.ex_alu_result = alu;
        bus.ex_store_data = sd;
        bus.mem_stall     = stall;
        bus.flush         = fl;
        bus.mem_read_data = rdata;
        reset             = rst;
        @(posedge clk);
        model_edge();
        mon_en = 1'b1;
        #1;
    endtask

    task automatic idle(input bit stall, input bit fl);
        step(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, stall, fl, 0, 32'h0);
    endtask

    // Monitor: samples on the falling edge and checks against the model/scoreboard.
    always @(negedge clk) begin
        wb_t w;
        if (mon_en) begin
            chk("ex_hold", {31'd0, bus.ex_hold}, {31'd0, bus.mem_stall});
            if (after_reset) begin
                chk("rst_ex_mem_all", {bus.EX_MEM_alu_result ^ bus.EX_MEM_store_data}
                    | {27'd0, bus.EX_MEM_rd} | {31'd0, bus.EX_MEM_valid}, 32'd0);
                chk("rst_ex_mem_data", bus.EX_MEM_alu_result | bus.EX_MEM_store_data, 32'd0);
                chk("rst_mem_wb_data", bus.MEM_WB_alu_result | bus.MEM_WB_read_data, 32'd0);
            end
            chk("ex_mem_valid", {31'd0, bus.EX_MEM_valid}, {31'd0, mem_slot.valid});
            chk("ex_mem_ctl", {29'd0, bus.EX_MEM_regWrite, bus.EX_MEM_memRead, bus.EX_MEM_memWrite},
                {29'd0, mem_slot.rw, mem_slot.mr, mem_slot.mw});
            chk("ex_mem_rd", {27'd0, bus.EX_MEM_rd}, {27'd0, mem_slot.dest});
            if (mem_slot.valid) begin
                chk("ex_mem_alu", bus.EX_MEM_alu_result, mem_slot.alu);
                chk("ex_mem_sd", bus.EX_MEM_store_data, mem_slot.sd);
            end
            chk("mem_wb_valid", {31'd0, bus.MEM_WB_valid}, {31'd0, exp_wb_valid});
            if (bus.MEM_WB_valid) begin
                if (wb_q.size() == 0) begin
                    chk("mem_wb_unexpected", 32'd1, 32'd0);
                end else begin
                    w = wb_q.pop_front();
                    chk("mem_wb_rd", {27'd0, bus.MEM_WB_rd}, {27'd0, w.rd});
                    chk("mem_wb_rt", {27'd0, bus.MEM_WB_rt}, {27'd0, w.rt});
                    chk("mem_wb_ctl", {30'd0, bus.MEM_WB_regWrite, bus.MEM_WB_memToReg},
                        {30'd0, w.rw, w.m2r});
                    chk("mem_wb_alu", bus.MEM_WB_alu_result, w.alu);
                    chk("mem_wb_rdata", bus.MEM_WB_read_data, w.rdata);
                end
            end else begin
                chk("mem_wb_bubble", {20'd0, bus.MEM_WB_regWrite, bus.MEM_WB_memToReg,
                    bus.MEM_WB_rd, bus.MEM_WB_rt}, 32'd0);
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        mon_en = 1'b0;
        mem_slot = '{default: '0};
        pend = 1'b0;
        exp_wb_valid = 1'b0;
        after_reset = 1'b0;

        // Reset with stall and flush also high: reset wins.
        step(1, 1, 0, 0, 5'd1, 5'd2, 32'h11, 32'h22, 1, 1, 1, 32'h0);
        step(1, 1, 0, 0, 5'd1, 5'd2, 32'h11, 32'h22, 1, 1, 1, 32'h0);

        // Three back-to-back R-types.
        step(1, 1, 0, 0, 5'd3, 5'd0, 32'h1003, 32'h0, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 5'd4, 5'd0, 32'h1004, 32'h0, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 5'd5, 5'd0, 32'h1005, 32'h0, 0, 0, 0, 32'h0);

        // Load rt=7 rd=9, read data returned while it sits in MEM.
        step(1, 1, 1, 0, 5'd9, 5'd7, 32'h2000, 32'h0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 32'hDEADBEEF);

        // Store held by a two-cycle memory stall.
        step(1, 0, 0, 1, 5'd0, 5'd6, 32'h3000, 32'hCAFE0001, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 5'd8, 5'd0, 32'h3004, 32'h0, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 5'd8, 5'd0, 32'h3004, 32'h0, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 5'd8, 5'd0, 32'h3004, 32'h0, 0, 0, 0, 32'h5);
        idle(0, 0);

        // Flush during a stall: deferred, EX/MEM gets a bubble on release.
        step(1, 1, 0, 0, 5'd10, 5'd0, 32'h4000, 32'h0, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 5'd11, 5'd0, 32'h4004, 32'h0, 1, 1, 0, 32'h0);
        step(1, 1, 0, 0, 5'd11, 5'd0, 32'h4004, 32'h0, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 5'd12, 5'd0, 32'h4008, 32'h0, 0, 0, 0, 32'h0);
        idle(0, 0);

        // Reset mid-stream with stall and flush asserted.
        step(1, 1, 0, 0, 5'd13, 5'd0, 32'h5000, 32'h0, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 5'd14, 5'd0, 32'h5004, 32'h0, 1, 1, 1, 32'h0);
        step(1, 1, 0, 0, 5'd15, 5'd0, 32'h5008, 32'h0, 0, 0, 0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit v, mr, mw, rw;
            v  = ($urandom % 4) != 0;
            mr = ($urandom % 3) == 0;
            mw = !mr && (($urandom % 3) == 0);
            rw = mr || (!mw && ($urandom % 2 == 1));
            step(v, rw, mr, mw, 5'($urandom), 5'($urandom), $urandom, $urandom,
                 ($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 60) == 0, $urandom);
        end

        idle(0, 0);
        idle(0, 0);
        idle(0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard_empty", wb_q.size(), 32'd0);
`ifdef EX_MEM_WB_PERF_EN
        chk("perf_stall", bus.perf_stall_cnt, m_stall);
        chk("perf_bubble", bus.perf_bubble_cnt, m_bub);
        chk("perf_retire", bus.perf_retire_cnt, m_ret);
`endif
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
